// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   RESET_PC_DEFAULT : first fetch address after reset
//   NOP_WORD         : instruction word held in IF/ID while it is empty
//   PC_INCREMENT     : sequential fetch stride in bytes
//   fetch_state_e    : BOOT / RUN fetch sequencer state
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] PC_INCREMENT     = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the synchronous
// instruction ROM address, pairs the ROM's one-cycle-late data with its PC
// and holds the IF/ID pipeline register. Single delay slot: a redirect
// never squashes the word already in flight.
//
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   stall_in                     freezes PC and IF/ID
//   redirect_in, redirect_pc_in  taken branch/jump and its target
//   rom_addr_out                 combinational ROM address
//   rom_data_in                  ROM word for the address of the previous edge
//   ifid_valid/instr/pc/pc4_out  IF/ID register contents
//   misaligned_out               sticky: a taken target had nonzero bits [1:0]
//   fetch_count_out              instructions captured into IF/ID
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | first cycle after reset; ROM is being primed with RESET_PC
// RUN   | normal fetch; left only by reset
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [31:0]      redirect_pc_in,
  output logic [31:0]      rom_addr_out,
  input  logic [31:0]      rom_data_in,
  output logic             ifid_valid_out,
  output logic [31:0]      ifid_instr_out,
  output logic [31:0]      ifid_pc_out,
  output logic [31:0]      ifid_pc4_out,
  output logic             misaligned_out,
  output logic [CNT_W-1:0] fetch_count_out
);

  fetch_state_e     state_q, state_d;
  logic             fetch_vld_q, fetch_vld_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             ifid_valid_q, ifid_valid_d;
  logic [31:0]      ifid_instr_q, ifid_instr_d;
  logic [31:0]      ifid_pc_q, ifid_pc_d;
  logic [31:0]      ifid_pc4_q, ifid_pc4_d;
  logic             misaligned_q, misaligned_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;
  logic [31:0]      rom_addr_c;

  always_comb begin
    state_d       = state_q;
    fetch_vld_d   = fetch_vld_q;
    fetch_pc_d    = fetch_pc_q;
    ifid_valid_d  = ifid_valid_q;
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_pc4_d    = ifid_pc4_q;
    misaligned_d  = misaligned_q;
    fetch_count_d = fetch_count_q;
    rom_addr_c    = RESET_PC;

    if (state_q == BOOT) begin
      // Nothing real is on rom_data_in yet, so IF/ID stays empty here.
      rom_addr_c  = RESET_PC;
      fetch_pc_d  = RESET_PC;
      fetch_vld_d = 1'b1;
      state_d     = RUN;
    end else begin
      // Stall wins over redirect: the branch is held in decode and the
      // redirect is re-presented once the stall drops.
      if (stall_in) begin
        rom_addr_c = fetch_pc_q;
      end else if (redirect_in) begin
        rom_addr_c = {redirect_pc_in[31:2], 2'b00};
        if (redirect_pc_in[1:0] != 2'b00) begin
          misaligned_d = 1'b1;
        end
      end else begin
        rom_addr_c = fetch_pc_q + PC_INCREMENT;
      end
      fetch_pc_d = rom_addr_c;

      if (!stall_in) begin
        ifid_valid_d = fetch_vld_q;
        ifid_instr_d = rom_data_in;
        ifid_pc_d    = fetch_pc_q;
        ifid_pc4_d   = fetch_pc_q + PC_INCREMENT;
        if (fetch_vld_q) begin
          fetch_count_d = fetch_count_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= BOOT;
      fetch_vld_q   <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      ifid_valid_q  <= 1'b0;
      ifid_instr_q  <= NOP_WORD;
      ifid_pc_q     <= 32'h0;
      ifid_pc4_q    <= 32'h0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      fetch_vld_q   <= fetch_vld_d;
      fetch_pc_q    <= fetch_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_pc4_q    <= ifid_pc4_d;
      misaligned_q  <= misaligned_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rom_addr_out    = rom_addr_c;
  assign ifid_valid_out  = ifid_valid_q;
  assign ifid_instr_out  = ifid_instr_q;
  assign ifid_pc_out     = ifid_pc_q;
  assign ifid_pc4_out    = ifid_pc4_q;
  assign misaligned_out  = misaligned_q;
  assign fetch_count_out = fetch_count_q;

endmodule
